// File: rtl/ex_muldiv_ctrl_if.sv
// EX-stage to multiply/divide unit bundle: instruction request, flush, HI/LO and pipeline hold.
interface ex_muldiv_ctrl_if;
  logic        valid;
  logic [5:0]  alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;
  logic        busy;

  modport master (
    output valid, alu_op, op_a, op_b, flush,
    input  hi, lo, stall, busy
  );

  modport slave (
    input  valid, alu_op, op_a, op_b, flush,
    output hi, lo, stall, busy
  );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Iterative MIPS-style multiply/divide unit owning HI/LO, with MTHI/MTLO and pipeline stall.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle 33x33 signed multiply instead of shift-add.
module ex_muldiv_ctrl #(
  parameter int CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  ex_muldiv_ctrl_if.slave  bus
);

  localparam logic [5:0] ALU_MTHI  = 6'h11;
  localparam logic [5:0] ALU_MTLO  = 6'h13;
  localparam logic [5:0] ALU_MULT  = 6'h18;
  localparam logic [5:0] ALU_MULTU = 6'h19;
  localparam logic [5:0] ALU_DIV   = 6'h1A;
  localparam logic [5:0] ALU_DIVU  = 6'h1B;

  localparam logic [4:0] LAST_STEP = 5'(CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t      state_r;
  logic        busy_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] opnd_r;      // multiplicand or divisor
  logic [63:0] acc_r;       // {partial product | remainder, multiplier | dividend->quotient}
  logic [4:0]  count_r;
  logic        neg_res_r;
  logic        neg_rem_r;
  logic        div_zero_r;

  logic        is_mul_s;
  logic        is_div_s;
  logic        is_signed_s;
  logic        is_mthi_s;
  logic        is_mtlo_s;
  logic        start_s;
  logic        last_step_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [31:0] lat_opnd_s;
  logic [31:0] lat_low_s;
  logic [32:0] sum_s;
  logic [32:0] rem_shift_s;
  logic [32:0] diff_s;
  logic [63:0] mul_step_s;
  logic [63:0] div_step_s;
  logic [63:0] prod_fix_s;
  logic [31:0] quot_fix_s;
  logic [31:0] rem_fix_s;

`ifdef MULDIV_FAST_MUL_EN
  logic               signed_r;
  logic signed [32:0] fa_s;
  logic signed [32:0] fb_s;
  logic        [63:0] fast_prod_s;
`endif

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return 32'd0 - x;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? neg32(x) : x;
  endfunction

  // Opcode decode for the operations this unit owns
  always_comb begin
    is_mul_s    = 1'b0;
    is_div_s    = 1'b0;
    is_signed_s = 1'b0;
    is_mthi_s   = 1'b0;
    is_mtlo_s   = 1'b0;
    case (bus.alu_op)
      ALU_MULT:  begin is_mul_s = 1'b1; is_signed_s = 1'b1; end
      ALU_MULTU: begin is_mul_s = 1'b1; end
      ALU_DIV:   begin is_div_s = 1'b1; is_signed_s = 1'b1; end
      ALU_DIVU:  begin is_div_s = 1'b1; end
      ALU_MTHI:  begin is_mthi_s = 1'b1; end
      ALU_MTLO:  begin is_mtlo_s = 1'b1; end
      default:   begin is_mul_s = 1'b0; end
    endcase
  end

  assign start_s     = bus.valid & ~bus.flush & (state_r == IDLE) & (is_mul_s | is_div_s);
  assign last_step_s = (count_r == LAST_STEP);
  assign mag_a_s     = mag32(bus.op_a, is_signed_s);
  assign mag_b_s     = mag32(bus.op_b, is_signed_s);

  // Operand routing into the shared datapath registers on accept
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    if (is_mul_s) begin
      lat_opnd_s = bus.op_a;
      lat_low_s  = bus.op_b;
    end else begin
      lat_opnd_s = mag_b_s;
      lat_low_s  = mag_a_s;
    end
`else
    if (is_mul_s) begin
      lat_opnd_s = mag_a_s;
      lat_low_s  = mag_b_s;
    end else begin
      lat_opnd_s = mag_b_s;
      lat_low_s  = mag_a_s;
    end
`endif
  end

  // One shift-add multiply step and one restoring divide step, plus signed write-back fix-up
  always_comb begin
    sum_s       = {1'b0, acc_r[63:32]} + {1'b0, opnd_r};
    mul_step_s  = acc_r[0] ? {sum_s, acc_r[31:1]} : {1'b0, acc_r[63:1]};
    rem_shift_s = {acc_r[63:32], acc_r[31]};
    diff_s      = rem_shift_s - {1'b0, opnd_r};
    if (diff_s[32]) begin
      div_step_s = {rem_shift_s[31:0], acc_r[30:0], 1'b0};
    end else begin
      div_step_s = {diff_s[31:0], acc_r[30:0], 1'b1};
    end
    prod_fix_s = neg_res_r ? (64'd0 - mul_step_s) : mul_step_s;
    rem_fix_s  = neg_rem_r ? neg32(div_step_s[63:32]) : div_step_s[63:32];
    // Divide-by-zero leaves the dividend in the remainder; quotient is forced to all ones
    if (div_zero_r) begin
      quot_fix_s = 32'hFFFF_FFFF;
    end else begin
      quot_fix_s = neg_res_r ? neg32(div_step_s[31:0]) : div_step_s[31:0];
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  assign fa_s        = {signed_r & opnd_r[31], opnd_r};
  assign fb_s        = {signed_r & acc_r[31], acc_r[31:0]};
  assign fast_prod_s = $signed({{31{fa_s[32]}}, fa_s}) * $signed({{31{fb_s[32]}}, fb_s});
`endif

  // Control FSM, operand/step datapath and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      opnd_r     <= 32'd0;
      acc_r      <= 64'd0;
      count_r    <= 5'd0;
      neg_res_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
      signed_r   <= 1'b0;
`endif
    end else if (bus.flush) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      count_r <= 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            opnd_r     <= lat_opnd_s;
            acc_r      <= {32'd0, lat_low_s};
            count_r    <= 5'd0;
            neg_res_r  <= is_signed_s & (bus.op_a[31] ^ bus.op_b[31]);
            neg_rem_r  <= is_signed_s & bus.op_a[31];
            div_zero_r <= is_div_s & (bus.op_b == 32'd0);
`ifdef MULDIV_FAST_MUL_EN
            signed_r   <= is_signed_s;
`endif
            state_r    <= is_mul_s ? MUL : DIV;
            busy_r     <= 1'b1;
          end else if (bus.valid && is_mthi_s) begin
            hi_r <= bus.op_a;
          end else if (bus.valid && is_mtlo_s) begin
            lo_r <= bus.op_a;
          end else begin
            state_r <= IDLE;
          end
        end
        MUL: begin
`ifdef MULDIV_FAST_MUL_EN
          hi_r    <= fast_prod_s[63:32];
          lo_r    <= fast_prod_s[31:0];
          count_r <= 5'd0;
          state_r <= IDLE;
          busy_r  <= 1'b0;
`else
          acc_r <= mul_step_s;
          if (last_step_s) begin
            hi_r    <= prod_fix_s[63:32];
            lo_r    <= prod_fix_s[31:0];
            count_r <= 5'd0;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            count_r <= count_r + 5'd1;
          end
`endif
        end
        DIV: begin
          acc_r <= div_step_s;
          if (last_step_s) begin
            hi_r    <= rem_fix_s;
            lo_r    <= quot_fix_s;
            count_r <= 5'd0;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            count_r <= count_r + 5'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          count_r <= 5'd0;
        end
      endcase
    end
  end

  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.busy  = busy_r;
  assign bus.stall = start_s | busy_r;

endmodule
